// File: rtl/width_conv_fifo.sv
// Single-clock FIFO with width conversion: packs narrow beats into wide words (UP),
// splits wide words into narrow slices (DOWN), or stores words unchanged (PASS).
module width_conv_fifo #(
    parameter int DIN_W      = 16,
    parameter int DOUT_W     = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int FULL_SLACK = 1,
    localparam int R      = (DOUT_W > DIN_W) ? DOUT_W / DIN_W : DIN_W / DOUT_W,
    localparam int KEEP_W = (DOUT_W > DIN_W) ? DOUT_W / DIN_W : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_ena,
    input  logic [DIN_W-1:0]    wr_dat,
    input  logic                wr_last,
    output logic                wr_full,
    input  logic                rd_ena,
    output logic [DOUT_W-1:0]   rd_dat,
    output logic [KEEP_W-1:0]   rd_keep,
    output logic                rd_last,
    output logic                rd_empty,
    output logic [ADDR_WIDTH:0] rd_dat_cnt,
    output logic                ovf
);
    localparam bit UP    = DOUT_W > DIN_W;
    localparam bit DOWN  = DOUT_W < DIN_W;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SW    = UP ? DOUT_W : DIN_W;
    localparam int EW    = SW + KEEP_W + 1;
    localparam int LW    = (R > 1) ? $clog2(R) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_AT   = (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);

    // Each storage entry is {last, keep, data}.
    logic [ADDR_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic                ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [EW-1:0]       head;
    logic [EW-1:0]       push_entry;
    logic                wr_acc, push, push_ok, pop;

    assign rd_dat_cnt = wptr_q - rptr_q;
    assign rd_empty   = (rd_dat_cnt == '0);
    assign wr_full    = (rd_dat_cnt >= FULL_AT);
    assign wr_acc     = wr_ena & ~wr_full;
    assign push_ok    = push & (rd_dat_cnt != DEPTH_CNT);
    assign head       = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    assign ovf        = ovf_q;

    always_comb begin
        wptr_d = wptr_q + (ADDR_WIDTH+1)'(push_ok);
        rptr_d = rptr_q + (ADDR_WIDTH+1)'(pop);
        ovf_d  = ovf_q | (wr_ena & wr_full) | (push & ~push_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= push_entry;
    end

    if (!DOWN) begin : g_pack
        // Completed words sit in a staging register for one cycle before entering storage.
        logic [DOUT_W-1:0] pack_q, pack_d, merged, stg_dat_q, stg_dat_d;
        logic [LW-1:0]     lane_q, lane_d;
        logic [KEEP_W-1:0] fill_mask, stg_keep_q, stg_keep_d;
        logic              stg_vld_q, stg_vld_d, stg_last_q, stg_last_d;

        always_comb begin
            merged = pack_q;
            merged[int'(lane_q)*DIN_W +: DIN_W] = wr_dat;
            fill_mask = '0;
            for (int i = 0; i < KEEP_W; i++) fill_mask[i] = (LW'(i) <= lane_q);
            pack_d     = pack_q;
            lane_d     = lane_q;
            stg_vld_d  = 1'b0;
            stg_dat_d  = stg_dat_q;
            stg_keep_d = stg_keep_q;
            stg_last_d = stg_last_q;
            if (wr_acc) begin
                if (wr_last || lane_q == LW'(R - 1)) begin
                    stg_vld_d  = 1'b1;
                    stg_dat_d  = merged;
                    stg_keep_d = fill_mask;
                    stg_last_d = wr_last;
                    pack_d     = '0;
                    lane_d     = '0;
                end else begin
                    pack_d = merged;
                    lane_d = lane_q + LW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pack_q     <= '0;
                lane_q     <= '0;
                stg_vld_q  <= 1'b0;
                stg_dat_q  <= '0;
                stg_keep_q <= '0;
                stg_last_q <= 1'b0;
            end else begin
                pack_q     <= pack_d;
                lane_q     <= lane_d;
                stg_vld_q  <= stg_vld_d;
                stg_dat_q  <= stg_dat_d;
                stg_keep_q <= stg_keep_d;
                stg_last_q <= stg_last_d;
            end
        end

        assign push       = stg_vld_q;
        assign push_entry = {stg_last_q, stg_keep_q, stg_dat_q};
        assign pop        = rd_ena & ~rd_empty;
        assign rd_dat     = rd_empty ? '0 : head[SW-1:0];
        assign rd_keep    = rd_empty ? '0 : head[SW +: KEEP_W];
        assign rd_last    = ~rd_empty & head[EW-1];
    end else begin : g_split
        // The head word is only popped once its final slice has been read.
        logic [LW-1:0] slice_q, slice_d;
        logic          last_slice;

        assign last_slice = (slice_q == LW'(R - 1));

        always_comb begin
            slice_d = slice_q;
            if (rd_ena && !rd_empty) slice_d = last_slice ? '0 : slice_q + LW'(1);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) slice_q <= '0;
            else       slice_q <= slice_d;
        end

        assign push       = wr_acc;
        assign push_entry = {wr_last, 1'b1, wr_dat};
        assign pop        = rd_ena & ~rd_empty & last_slice;
        assign rd_dat     = rd_empty ? '0 : head[int'(slice_q)*DOUT_W +: DOUT_W];
        assign rd_keep    = rd_empty ? '0 : head[SW +: KEEP_W];
        assign rd_last    = ~rd_empty & last_slice & head[EW-1];
    end
endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo with UP 16->64, DOWN 64->16 and PASS 16->16 instances, driven
// by vector tables, corner-case sequences and randomized traffic against a packing model.
module tb_width_conv_fifo;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        upWrEna, upWrLast, upRdEna, upWrFull, upRdLast, upRdEmpty, upOvf;
    logic [15:0] upWrDat;
    logic [63:0] upRdDat;
    logic [3:0]  upRdKeep, upCnt;

    logic        dnWrEna, dnWrLast, dnRdEna, dnWrFull, dnRdLast, dnRdEmpty, dnOvf;
    logic [63:0] dnWrDat;
    logic [15:0] dnRdDat;
    logic [0:0]  dnRdKeep;
    logic [3:0]  dnCnt;

    logic        psWrEna, psWrLast, psRdEna, psWrFull, psRdLast, psRdEmpty, psOvf;
    logic [15:0] psWrDat, psRdDat;
    logic [0:0]  psRdKeep;
    logic [2:0]  psCnt;

    width_conv_fifo #(.DIN_W(16), .DOUT_W(64), .ADDR_WIDTH(3), .FULL_SLACK(1)) uUp (
        .clk(clk), .rstn(rstn), .wr_ena(upWrEna), .wr_dat(upWrDat), .wr_last(upWrLast),
        .wr_full(upWrFull), .rd_ena(upRdEna), .rd_dat(upRdDat), .rd_keep(upRdKeep),
        .rd_last(upRdLast), .rd_empty(upRdEmpty), .rd_dat_cnt(upCnt), .ovf(upOvf));

    width_conv_fifo #(.DIN_W(64), .DOUT_W(16), .ADDR_WIDTH(3), .FULL_SLACK(1)) uDown (
        .clk(clk), .rstn(rstn), .wr_ena(dnWrEna), .wr_dat(dnWrDat), .wr_last(dnWrLast),
        .wr_full(dnWrFull), .rd_ena(dnRdEna), .rd_dat(dnRdDat), .rd_keep(dnRdKeep),
        .rd_last(dnRdLast), .rd_empty(dnRdEmpty), .rd_dat_cnt(dnCnt), .ovf(dnOvf));

    width_conv_fifo #(.DIN_W(16), .DOUT_W(16), .ADDR_WIDTH(2), .FULL_SLACK(0)) uPass (
        .clk(clk), .rstn(rstn), .wr_ena(psWrEna), .wr_dat(psWrDat), .wr_last(psWrLast),
        .wr_full(psWrFull), .rd_ena(psRdEna), .rd_dat(psRdDat), .rd_keep(psRdKeep),
        .rd_last(psRdLast), .rd_empty(psRdEmpty), .rd_dat_cnt(psCnt), .ovf(psOvf));

    typedef struct {
        int          nBeats;
        logic [63:0] beats;
        logic        lastFinal;
        logic [63:0] expDat;
        logic [3:0]  expKeep;
        logic        expLast;
    } upVec_t;

    typedef struct {
        logic [63:0] dat;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    upVec_t      upVecs [5];
    logic [63:0] dnWords [3];
    logic        dnLasts [3];
    word_t       stored [$];
    word_t       pending;
    bit          pendingVld;
    logic [63:0] curWord;
    int          curN;
    bit          modelOvf;
    int          expCnt;
    bit          expFull;
    logic        wrE, rdE, lastB;
    logic [15:0] rndDat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dat, input logic last);
        upWrEna  = 1'b1;
        upWrDat  = dat;
        upWrLast = last;
        tick();
        upWrEna  = 1'b0;
        upWrLast = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_up_empty"}, upRdEmpty, 1);
        checkOutput({tag, "_up_full"}, upWrFull, 0);
        checkOutput({tag, "_up_cnt"}, upCnt, 0);
        checkOutput({tag, "_up_ovf"}, upOvf, 0);
        checkOutput({tag, "_up_dat"}, upRdDat, 0);
        checkOutput({tag, "_up_keep"}, upRdKeep, 0);
        checkOutput({tag, "_up_last"}, upRdLast, 0);
        checkOutput({tag, "_dn_empty"}, dnRdEmpty, 1);
        checkOutput({tag, "_dn_dat"}, dnRdDat, 0);
        checkOutput({tag, "_dn_keep"}, dnRdKeep, 0);
        checkOutput({tag, "_ps_empty"}, psRdEmpty, 1);
        checkOutput({tag, "_ps_ovf"}, psOvf, 0);
    endtask

    initial begin
        rstn = 1'b0;
        {upWrEna, upWrLast, upRdEna, dnWrEna, dnWrLast, dnRdEna, psWrEna, psWrLast, psRdEna} = '0;
        upWrDat = '0;
        dnWrDat = '0;
        psWrDat = '0;

        upVecs[0] = '{4, 64'h4444_3333_2222_1111, 1'b1, 64'h4444_3333_2222_1111, 4'b1111, 1'b1};
        upVecs[1] = '{3, 64'h0000_CCCC_BBBB_AAAA, 1'b1, 64'h0000_CCCC_BBBB_AAAA, 4'b0111, 1'b1};
        upVecs[2] = '{1, 64'h0000_0000_0000_5A5A, 1'b1, 64'h0000_0000_0000_5A5A, 4'b0001, 1'b1};
        upVecs[3] = '{4, 64'h5678_1234_BEEF_DEAD, 1'b0, 64'h5678_1234_BEEF_DEAD, 4'b1111, 1'b0};
        upVecs[4] = '{2, 64'h0000_0000_F0F0_0F0F, 1'b1, 64'h0000_0000_F0F0_0F0F, 4'b0011, 1'b1};
        dnWords[0] = 64'h4444_3333_2222_1111; dnLasts[0] = 1'b1;
        dnWords[1] = 64'h8877_6655_4433_2211; dnLasts[1] = 1'b0;
        dnWords[2] = 64'h0123_4567_89AB_CDEF; dnLasts[2] = 1'b1;

        tick();
        tick();
        checkResetOutputs("reset");
        rstn = 1'b1;
        tick();
        checkResetOutputs("post_reset");

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < upVecs[v].nBeats; b++)
                applyStimulus(upVecs[v].beats[16*b +: 16],
                              upVecs[v].lastFinal && (b == upVecs[v].nBeats - 1));
            checkOutput($sformatf("up%0d_stage_empty", v), upRdEmpty, 1);
            tick();
            checkOutput($sformatf("up%0d_empty", v), upRdEmpty, 0);
            checkOutput($sformatf("up%0d_dat", v), upRdDat, upVecs[v].expDat);
            checkOutput($sformatf("up%0d_keep", v), upRdKeep, upVecs[v].expKeep);
            checkOutput($sformatf("up%0d_last", v), upRdLast, upVecs[v].expLast);
            upRdEna = 1'b1;
            tick();
            upRdEna = 1'b0;
            checkOutput($sformatf("up%0d_drained", v), upRdEmpty, 1);
        end

        // Wide words are visible right after the accepting edge and read out LSB slice first.
        for (int w = 0; w < 3; w++) begin
            dnWrEna  = 1'b1;
            dnWrDat  = dnWords[w];
            dnWrLast = dnLasts[w];
            tick();
            if (w == 0) checkOutput("dn_first_visible", dnRdEmpty, 0);
        end
        dnWrEna = 1'b0;
        checkOutput("dn_cnt", dnCnt, 3);
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < 4; s++) begin
                checkOutput($sformatf("dn_w%0d_s%0d_dat", w, s), dnRdDat, dnWords[w][16*s +: 16]);
                checkOutput($sformatf("dn_w%0d_s%0d_last", w, s), dnRdLast, dnLasts[w] && s == 3);
                checkOutput($sformatf("dn_w%0d_s%0d_keep", w, s), dnRdKeep, 1);
                dnRdEna = 1'b1;
                tick();
                dnRdEna = 1'b0;
            end
        end
        checkOutput("dn_empty_after", dnRdEmpty, 1);
        checkOutput("dn_cnt_after", dnCnt, 0);

        // Streaming through the 4-deep PASS instance wraps the pointers three times.
        for (int k = 0; k < 14; k++) begin
            if (k >= 2) begin
                checkOutput($sformatf("ps_stream%0d_dat", k), psRdDat, 16'hC000 + 16'(k - 2));
                checkOutput($sformatf("ps_stream%0d_cnt", k), psCnt, 1);
            end
            psWrEna = (k < 12);
            psWrDat = 16'hC000 + 16'(k);
            psRdEna = (k >= 2);
            tick();
        end
        psWrEna = 1'b0;
        psRdEna = 1'b0;
        checkOutput("ps_stream_empty", psRdEmpty, 1);
        checkOutput("ps_stream_ovf", psOvf, 0);

        for (int i = 0; i < 5; i++) begin
            psWrEna = 1'b1;
            psWrDat = 16'h1001 + 16'(i);
            tick();
        end
        psWrEna = 1'b0;
        checkOutput("ps_full_after_4th", psWrFull, 1);
        checkOutput("ps_cnt_after_4th", psCnt, 4);
        tick();
        checkOutput("ps_ovf_discard", psOvf, 1);
        checkOutput("ps_cnt_held", psCnt, 4);
        psWrEna = 1'b1;
        psWrDat = 16'hBAD0;
        tick();
        psWrEna = 1'b0;
        checkOutput("ps_cnt_drop", psCnt, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ps_read%0d", i), psRdDat, 16'h1001 + 16'(i));
            psRdEna = 1'b1;
            tick();
            psRdEna = 1'b0;
        end
        checkOutput("ps_empty_after_reads", psRdEmpty, 1);
        checkOutput("ps_ovf_sticky", psOvf, 1);

        // Randomized UP traffic: model packs beats into words and queues them with one cycle of delay.
        stored.delete();
        pendingVld = 1'b0;
        curWord    = '0;
        curN       = 0;
        modelOvf   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            expCnt  = stored.size();
            expFull = (expCnt >= 7);
            checkOutput($sformatf("rand%0d_cnt", c), upCnt, 64'(expCnt));
            checkOutput($sformatf("rand%0d_empty", c), upRdEmpty, expCnt == 0);
            checkOutput($sformatf("rand%0d_full", c), upWrFull, expFull);
            checkOutput($sformatf("rand%0d_ovf", c), upOvf, modelOvf);
            if (expCnt > 0) begin
                checkOutput($sformatf("rand%0d_dat", c), upRdDat, stored[0].dat);
                checkOutput($sformatf("rand%0d_keep", c), upRdKeep, stored[0].keep);
                checkOutput($sformatf("rand%0d_last", c), upRdLast, stored[0].last);
            end
            wrE    = ($urandom_range(3) != 0);
            rdE    = (c < 200) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
            lastB  = ($urandom_range(4) == 0);
            rndDat = 16'($urandom);
            upWrEna  = wrE;
            upWrDat  = rndDat;
            upWrLast = lastB;
            upRdEna  = rdE;
            tick();
            if (rdE && expCnt > 0) void'(stored.pop_front());
            if (pendingVld) begin
                if (expCnt == 8) modelOvf = 1'b1;
                else             stored.push_back(pending);
                pendingVld = 1'b0;
            end
            if (wrE) begin
                if (expFull) begin
                    modelOvf = 1'b1;
                end else begin
                    curWord = curWord | (64'(rndDat) << (16 * curN));
                    curN++;
                    if (curN == 4 || lastB) begin
                        pending.dat  = curWord;
                        pending.keep = 4'((1 << curN) - 1);
                        pending.last = lastB;
                        pendingVld   = 1'b1;
                        curWord      = '0;
                        curN         = 0;
                    end
                end
            end
        end
        upWrEna  = 1'b0;
        upWrLast = 1'b0;
        upRdEna  = 1'b0;

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Build up partial state everywhere, then pull reset between clock edges.
        applyStimulus(16'h5A5A, 1'b1);
        applyStimulus(16'h1111, 1'b0);
        applyStimulus(16'h2222, 1'b0);
        dnWrEna  = 1'b1;
        dnWrDat  = 64'hDDDD_CCCC_BBBB_AAAA;
        dnWrLast = 1'b1;
        psWrEna  = 1'b1;
        psWrDat  = 16'h4242;
        tick();
        dnWrEna = 1'b0;
        psWrEna = 1'b0;
        dnRdEna = 1'b1;
        tick();
        dnRdEna = 1'b0;
        checkOutput("pre_rst_up_word", upRdDat, 64'h5A5A);
        checkOutput("pre_rst_dn_slice1", dnRdDat, 16'hBBBB);
        checkOutput("pre_rst_ps_nonempty", psRdEmpty, 0);
        #2;
        rstn = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        #1;
        rstn = 1'b1;
        applyStimulus(16'h7777, 1'b1);
        tick();
        checkOutput("post_rst_up_dat", upRdDat, 64'h7777);
        checkOutput("post_rst_up_keep", upRdKeep, 4'b0001);
        checkOutput("post_rst_up_last", upRdLast, 1);
        dnWrEna = 1'b1;
        dnWrDat = 64'h1234_5678_9ABC_DEF0;
        tick();
        dnWrEna = 1'b0;
        checkOutput("post_rst_dn_slice0", dnRdDat, 16'hDEF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
